// File: rtl/joybus_rx.sv
// joybus_rx: N64 Joybus response receiver; 24 pulse-width-coded bits (MSB first) plus a stop bit.
// Optional idle-line watchdog is compiled in when JOYBUS_RX_TIMEOUT_EN is defined.
module joybus_rx #(
   parameter int SAMPLE_CYCLES  = 50,
   parameter int NUM_BITS       = 24,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_start,
   input  logic        JB_RX,
   output logic        rx_done,
   output logic [7:0]  jb_cntlr_status,
   output logic [15:0] jb_cntlr_data
);
   localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_FALL, SAMPLE, WAIT_HIGH, STOP_FALL, STOP_HIGH, DONE
   } state_t;

   state_t            state;
   logic              sync0, sync1, hist;
   logic              fall;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        bit_cnt;
   logic [23:0]       shift;

   assign fall = hist & ~sync1;

`ifdef JOYBUS_RX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   logic [WD_W-1:0] wd;
   logic            watched, progress;

   assign watched  = (state == WAIT_FALL) || (state == WAIT_HIGH) ||
                     (state == STOP_FALL) || (state == STOP_HIGH);
   // Any forward step restarts the watchdog so it can never race a legal transition.
   assign progress = fall || (sync1 && ((state == WAIT_HIGH) || (state == STOP_HIGH)));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         // Synchronizer starts at the idle-high level so reset release never looks like an edge.
         sync0           <= 1'b1;
         sync1           <= 1'b1;
         hist            <= 1'b1;
         state           <= IDLE;
         cnt             <= '0;
         bit_cnt         <= '0;
         shift           <= '0;
         rx_done         <= 1'b0;
         jb_cntlr_status <= '0;
         jb_cntlr_data   <= '0;
`ifdef JOYBUS_RX_TIMEOUT_EN
         wd              <= '0;
`endif
      end else begin
         sync0   <= JB_RX;
         sync1   <= sync0;
         hist    <= sync1;
         rx_done <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_start) begin
                  bit_cnt <= '0;
                  state   <= WAIT_FALL;
               end
            end
            WAIT_FALL: begin
               if (fall) begin
                  cnt   <= CNT_W'(1);
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (cnt == CNT_W'(SAMPLE_CYCLES)) begin
                  shift   <= {shift[22:0], sync1};
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= WAIT_HIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (sync1)
                  state <= (bit_cnt == 5'(NUM_BITS)) ? STOP_FALL : WAIT_FALL;
            end
            STOP_FALL: begin
               if (fall)
                  state <= STOP_HIGH;
            end
            STOP_HIGH: begin
               if (sync1) begin
                  rx_done         <= 1'b1;
                  jb_cntlr_status <= shift[23:16];
                  jb_cntlr_data   <= shift[15:0];
                  state           <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

`ifdef JOYBUS_RX_TIMEOUT_EN
         if (!watched || progress) begin
            wd <= '0;
         end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd    <= '0;
            state <= IDLE;
         end else begin
            wd <= wd + 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_joybus_rx.sv
// Directed self-checking bench for joybus_rx: frames are built bit by bit at 25 clocks per us.
module tb_joybus_rx;
   logic        clk = 1'b0;
   logic        rst, rx_start, jb_rx;
   logic        rx_done;
   logic [7:0]  status;
   logic [15:0] data;

   int tests = 0, fails = 0, done_cnt = 0;

   joybus_rx dut (
      .clk             (clk),
      .rst             (rst),
      .rx_start        (rx_start),
      .JB_RX           (jb_rx),
      .rx_done         (rx_done),
      .jb_cntlr_status (status),
      .jb_cntlr_data   (data)
   );

   always #20 clk = ~clk;

   always @(negedge clk) if (rx_done) done_cnt++;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      rx_start = 1'b1;
      cyc(1);
      rx_start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      jb_rx = 1'b0;
      cyc(b ? 25 : 75);
      jb_rx = 1'b1;
      cyc(b ? 75 : 25);
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[23-i]);
   endtask

   task automatic send_stop();
      jb_rx = 1'b0;
      cyc(38);
      jb_rx = 1'b1;
      cyc(8);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_start = 1'b0; jb_rx = 1'b1;
      cyc(3);
      tests++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", rx_done); end
      tests++; if (status !== 8'h00) begin fails++; $display("FAIL reset_status: got %h expected 00", status); end
      tests++; if (data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", data); end
      rst = 1'b0;
      cyc(3);
   endtask

   task automatic test_basic();
      int d0, lat;
      d0 = done_cnt; lat = 0;
      pulse_start();
      send_bits(24'h057301, 24);
      jb_rx = 1'b0;
      cyc(38);
      jb_rx = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         if (rx_done && lat == 0) lat = i;
      end
      tests++; if (!(lat >= 1 && lat <= 5)) begin fails++; $display("FAIL basic_latency: got %0d cycles expected 1..5", lat); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'h05) begin fails++; $display("FAIL basic_status: got %h expected 05", status); end
      tests++; if (data !== 16'h7301) begin fails++; $display("FAIL basic_data: got %h expected 7301", data); end
   endtask

   task automatic test_reset_mid();
      int d0;
      d0 = done_cnt;
      pulse_start();
      send_bits(24'h123456, 10);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      tests++; if (status !== 8'h00) begin fails++; $display("FAIL rstmid_status_clear: got %h expected 00", status); end
      tests++; if (data !== 16'h0000) begin fails++; $display("FAIL rstmid_data_clear: got %h expected 0000", data); end
      pulse_start();
      send_bits(24'h050002, 24);
      send_stop();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rstmid_done_count: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'h05) begin fails++; $display("FAIL rstmid_status: got %h expected 05", status); end
      tests++; if (data !== 16'h0002) begin fails++; $display("FAIL rstmid_data: got %h expected 0002", data); end
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = done_cnt;
      pulse_start();
      send_bits(24'hFFFFFF, 24);
      send_stop();
      tests++; if (status !== 8'hFF) begin fails++; $display("FAIL b2b_status_ff: got %h expected ff", status); end
      tests++; if (data !== 16'hFFFF) begin fails++; $display("FAIL b2b_data_ffff: got %h expected ffff", data); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_done_first: got %0d expected 1", done_cnt - d0); end
      pulse_start();
      send_bits(24'h000000, 24);
      send_stop();
      tests++; if (status !== 8'h00) begin fails++; $display("FAIL b2b_status_00: got %h expected 00", status); end
      tests++; if (data !== 16'h0000) begin fails++; $display("FAIL b2b_data_0000: got %h expected 0000", data); end
      tests++; if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done_total: got %0d expected 2", done_cnt - d0); end
   endtask

   task automatic test_no_start();
      int d0;
      d0 = done_cnt;
      send_bits(24'hA5C33C, 24);
      send_stop();
      cyc(5);
      tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL nostart_done: got %0d expected 0", done_cnt - d0); end
      tests++; if (status !== 8'h00) begin fails++; $display("FAIL nostart_status: got %h expected 00", status); end
      tests++; if (data !== 16'h0000) begin fails++; $display("FAIL nostart_data: got %h expected 0000", data); end
   endtask

   task automatic test_edge_start();
      int d0;
      d0 = done_cnt;
      // First bit of 0xC0FFEE is '1': its low phase starts in the rx_start cycle.
      rx_start = 1'b1;
      jb_rx    = 1'b0;
      cyc(1);
      rx_start = 1'b0;
      cyc(24);
      jb_rx = 1'b1;
      cyc(75);
      send_bits(24'hC0FFEE << 1, 23);
      send_stop();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL edge_done: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'hC0) begin fails++; $display("FAIL edge_status: got %h expected c0", status); end
      tests++; if (data !== 16'hFFEE) begin fails++; $display("FAIL edge_data: got %h expected ffee", data); end
   endtask

   task automatic test_rearm_ignored();
      int d0;
      d0 = done_cnt;
      pulse_start();
      send_bits(24'h3CA55A, 6);
      pulse_start();
      send_bits(24'h3CA55A << 6, 18);
      send_stop();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rearm_done: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'h3C) begin fails++; $display("FAIL rearm_status: got %h expected 3c", status); end
      tests++; if (data !== 16'hA55A) begin fails++; $display("FAIL rearm_data: got %h expected a55a", data); end
   endtask

`ifdef JOYBUS_RX_TIMEOUT_EN
   task automatic test_timeout();
      int d0;
      d0 = done_cnt;
      pulse_start();
      send_bits(24'h9ABCDE, 12);
      cyc(3000);
      tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL timeout_done: got %0d expected 0", done_cnt - d0); end
      tests++; if (status !== 8'h3C) begin fails++; $display("FAIL timeout_status_hold: got %h expected 3c", status); end
      tests++; if (data !== 16'hA55A) begin fails++; $display("FAIL timeout_data_hold: got %h expected a55a", data); end
      pulse_start();
      send_bits(24'h0A0B0C, 24);
      send_stop();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL timeout_next_done: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'h0A) begin fails++; $display("FAIL timeout_next_status: got %h expected 0a", status); end
      tests++; if (data !== 16'h0B0C) begin fails++; $display("FAIL timeout_next_data: got %h expected 0b0c", data); end
   endtask
`else
   task automatic test_timeout();
      int d0;
      d0 = done_cnt;
      // Without the watchdog the receiver keeps waiting across a long idle gap.
      pulse_start();
      send_bits(24'h9ABCDE, 12);
      cyc(3000);
      tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL nowd_gap_done: got %0d expected 0", done_cnt - d0); end
      send_bits(24'h9ABCDE << 12, 12);
      send_stop();
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL nowd_done: got %0d expected 1", done_cnt - d0); end
      tests++; if (status !== 8'h9A) begin fails++; $display("FAIL nowd_status: got %h expected 9a", status); end
      tests++; if (data !== 16'hBCDE) begin fails++; $display("FAIL nowd_data: got %h expected bcde", data); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_back_to_back();
      test_no_start();
      test_edge_start();
      test_rearm_ignored();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
